// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Holds the R-type funct codes that the sequencer decodes and the
// sequencer state type.
package muldiv_ctrl_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  // True for the four funct codes that start an iterative operation.
  function automatic logic is_muldiv(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

  // True for the two divide funct codes.
  function automatic logic is_div(input logic [5:0] f);
    return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
  endfunction

  // True for the two signed funct codes.
  function automatic logic is_signed_op(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Datapath for the iterative multiply/divide: a 2*WIDTH accumulator, the
// multiplicand/divisor register and the multiplier shift register, plus
// one shift-add (multiply) or shift-trial-subtract (divide) step per
// enabled cycle. Operands arrive as unsigned magnitudes.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_load        latch i_a/i_b and the mode (i_div)
//   i_div         1 = restoring divide, 0 = shift-add multiply (at load)
//   i_step        perform one iteration this cycle
//   i_align       multiply only: after this step, shift the accumulator
//                 right by i_align_sh more places (early completion)
//   i_align_sh    extra right-shift amount used with i_align
//   i_a, i_b      multiplicand/dividend, multiplier/divisor magnitudes
//   o_hi, o_lo    accumulator halves: product, or {remainder, quotient}
//   o_rest_zero   multiplier bits above bit 0 are all zero
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_load,
  input  logic                         i_div,
  input  logic                         i_step,
  input  logic                         i_align,
  input  logic [$clog2(WIDTH)-1:0]     i_align_sh,
  input  logic [WIDTH-1:0]             i_a,
  input  logic [WIDTH-1:0]             i_b,
  output logic [WIDTH-1:0]             o_hi,
  output logic [WIDTH-1:0]             o_lo,
  output logic                         o_rest_zero
);

  logic                 r_div;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_d;
  logic [WIDTH-1:0]     r_mplier;

  logic [WIDTH-1:0]     w_hi;
  logic [WIDTH-1:0]     w_lo;
  logic [WIDTH:0]       w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_mul_acc;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_div_acc;
  logic [2*WIDTH-1:0]   w_acc_nx;

  always_comb begin
    w_hi      = r_acc[2*WIDTH-1:WIDTH];
    w_lo      = r_acc[WIDTH-1:0];
    // Multiply: add into the upper half with the carry kept, then shift
    // the whole WIDTH+1+WIDTH-1 bit result right by one.
    w_addend  = r_mplier[0] ? {1'b0, r_d} : '0;
    w_sum     = {1'b0, w_hi} + w_addend;
    w_mul_acc = {w_sum, w_lo[WIDTH-1:1]};
    // Divide: {rem,quo} << 1, then trial subtract in WIDTH+1 bits.
    w_rem_sh  = {w_hi, w_lo[WIDTH-1]};
    w_diff    = w_rem_sh - {1'b0, r_d};
    if (w_diff[WIDTH]) begin
      w_div_acc = {w_rem_sh[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b0};
    end else begin
      w_div_acc = {w_diff[WIDTH-1:0], w_lo[WIDTH-2:0], 1'b1};
    end
    if (r_div) begin
      w_acc_nx = w_div_acc;
    end else if (i_align) begin
      w_acc_nx = w_mul_acc >> i_align_sh;
    end else begin
      w_acc_nx = w_mul_acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div    <= 1'b0;
      r_acc    <= '0;
      r_d      <= '0;
      r_mplier <= '0;
    end else if (i_load) begin
      r_div    <= i_div;
      r_d      <= i_div ? i_b : i_a;
      r_mplier <= i_div ? '0 : i_b;
      r_acc    <= i_div ? {{WIDTH{1'b0}}, i_a} : '0;
    end else if (i_step) begin
      r_acc    <= w_acc_nx;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign o_hi        = r_acc[2*WIDTH-1:WIDTH];
  assign o_lo        = r_acc[WIDTH-1:0];
  assign o_rest_zero = (r_mplier[WIDTH-1:1] == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the execute stage. Decodes
// MULT/MULTU/DIV/DIVU/MTHI/MTLO, runs a 32-step iterative operation in
// muldiv_iter, applies sign correction and commits to HI/LO.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        issue strobe, sampled only while idle
//   fncode       R-type funct of the issuing instruction
//   op_a, op_b   rs / rt values
//   busy         operation in flight
//   done         one-cycle pulse when HI/LO take a mul/div result
//   div_by_zero  one-cycle pulse with done for a divide by zero
//   hi, lo       architectural HI/LO
//
// Build option: define MULDIV_EARLY_TERM_EN to end a multiply as soon as
// the remaining multiplier bits are zero.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       fncode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned     CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  muldiv_state_t      r_state;
  muldiv_state_t      w_state_nx;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dbz_pulse;

  logic               w_is_md;
  logic               w_is_div;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_load;
  logic               w_step;
  logic               w_align;
  logic [CW-1:0]      w_align_sh;
  logic               w_commit;
  logic               w_wr_hi;
  logic               w_wr_lo;
  logic [WIDTH-1:0]   w_it_hi;
  logic [WIDTH-1:0]   w_it_lo;
  logic               w_rest_zero;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  // Operand decode and magnitudes for the signed forms.
  always_comb begin
    w_is_md  = is_muldiv(fncode);
    w_is_div = is_div(fncode);
    w_a_neg  = is_signed_op(fncode) && op_a[WIDTH-1];
    w_b_neg  = is_signed_op(fncode) && op_b[WIDTH-1];
    w_mag_a  = w_a_neg ? (~op_a + 1'b1) : op_a;
    w_mag_b  = w_b_neg ? (~op_b + 1'b1) : op_b;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_align    = 1'b0;
    w_align_sh = '0;
    w_commit   = 1'b0;
    w_wr_hi    = 1'b0;
    w_wr_lo    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_is_md) begin
            w_load = 1'b1;
            if (w_is_div && (op_b == '0)) begin
              w_state_nx = FIX;
            end
`ifdef MULDIV_EARLY_TERM_EN
            else if (op_b == '0) begin
              w_state_nx = FIX;
            end
`endif
            else begin
              w_state_nx = RUN;
            end
          end else if (fncode == FUNCT_MTHI) begin
            w_wr_hi = 1'b1;
          end else if (fncode == FUNCT_MTLO) begin
            w_wr_lo = 1'b1;
          end
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_state_nx = FIX;
        end
`ifdef MULDIV_EARLY_TERM_EN
        // Last useful multiplier bit consumed this step: the remaining
        // shifts are folded into a single alignment shift.
        if (!r_is_div && w_rest_zero) begin
          w_align    = 1'b1;
          w_align_sh = CNT_LAST - r_cnt;
          w_state_nx = FIX;
        end
`endif
      end
      FIX: begin
        w_commit   = 1'b1;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

`ifndef MULDIV_EARLY_TERM_EN
  logic w_unused_rest;
  assign w_unused_rest = w_rest_zero;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (w_step) begin
      r_cnt <= (w_state_nx == RUN) ? r_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dbz    <= 1'b0;
    end else if (w_load) begin
      r_is_div <= w_is_div;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      r_dbz    <= w_is_div && (op_b == '0);
    end
  end

  muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk         (clk),
    .rst_n       (reset),
    .i_load      (w_load),
    .i_div       (w_is_div),
    .i_step      (w_step),
    .i_align     (w_align),
    .i_align_sh  (w_align_sh),
    .i_a         (w_mag_a),
    .i_b         (w_mag_b),
    .o_hi        (w_it_hi),
    .o_lo        (w_it_lo),
    .o_rest_zero (w_rest_zero)
  );

  // Sign correction: product and quotient follow sign(a)^sign(b),
  // remainder follows sign(a).
  always_comb begin
    w_prod = {w_it_hi, w_it_lo};
    if (r_neg_q) begin
      w_prod = ~w_prod + 1'b1;
    end
    if (r_is_div) begin
      w_res_hi = r_neg_r ? (~w_it_hi + 1'b1) : w_it_hi;
      w_res_lo = r_neg_q ? (~w_it_lo + 1'b1) : w_it_lo;
    end else begin
      w_res_hi = w_prod[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi        <= '0;
      r_lo        <= '0;
      r_done      <= 1'b0;
      r_dbz_pulse <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_dbz_pulse <= 1'b0;
      if (w_wr_hi) begin
        r_hi <= op_a;
      end
      if (w_wr_lo) begin
        r_lo <= op_a;
      end
      if (w_commit) begin
        r_done <= 1'b1;
        if (r_dbz) begin
          r_dbz_pulse <= 1'b1;
        end else begin
          r_hi <= w_res_hi;
          r_lo <= w_res_lo;
        end
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz_pulse;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  fncode = 6'h00;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .fncode      (fncode),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  int          o_cyc, o_busy;
  logic        o_done, o_dbz, o_spur;
  logic [31:0] o_hi, o_lo;

  function automatic int hibit(input logic [31:0] v);
    int h = -1;
    for (int i = 0; i < 32; i++) if (v[i]) h = i;
    return h;
  endfunction

  function automatic int mul_lat(input logic [31:0] mb);
`ifdef MULDIV_EARLY_TERM_EN
    return (mb == 0) ? 2 : 3 + hibit(mb);
`else
    return 34 + 0 * hibit(mb);
`endif
  endfunction

  // Reference model: updates the model HI/LO and queues the expected commit.
  task automatic push_model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    longint sp, sa, sbv;
    e.dbz = 1'b0;
    case (fn)
      FUNCT_MTHI: begin m_hi = a; return; end
      FUNCT_MTLO: begin m_lo = a; return; end
      FUNCT_MULTU: begin
        p = {32'h0, a} * {32'h0, b};
        m_hi = p[63:32]; m_lo = p[31:0];
        e.lat = mul_lat(b);
      end
      FUNCT_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        p = sp;
        m_hi = p[63:32]; m_lo = p[31:0];
        e.lat = mul_lat(b[31] ? (~b + 32'd1) : b);
      end
      FUNCT_DIVU: begin
        if (b == 0) begin e.dbz = 1'b1; e.lat = 2; end
        else begin m_lo = a / b; m_hi = a % b; e.lat = 34; end
      end
      default: begin
        if (b == 0) begin e.dbz = 1'b1; e.lat = 2; end
        else begin
          sa = longint'($signed(a)); sbv = longint'($signed(b));
          sp = sa / sbv; m_lo = sp[31:0];
          sp = sa % sbv; m_hi = sp[31:0];
          e.lat = 34;
        end
      end
    endcase
    e.hi = m_hi; e.lo = m_lo;
    sb.push_back(e);
  endtask

  // Issues one op and watches the DUT until done (bounded); inj_cyc>0
  // drives a MULTU 5x6 start on that cycle while the op is running.
  task automatic run_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input int inj_cyc);
    start = 1'b1; fncode = fn; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; fncode = 6'h00; op_a = '0; op_b = '0;
    o_cyc = 1; o_busy = 0; o_done = 1'b0; o_dbz = 1'b0; o_spur = 1'b0;
    o_hi = '0; o_lo = '0;
    while (o_cyc <= 60) begin
      if (done) begin
        o_done = 1'b1; o_hi = hi; o_lo = lo; o_dbz = div_by_zero;
        break;
      end
      if (div_by_zero) o_spur = 1'b1;
      if (busy) o_busy++;
      if (o_cyc == inj_cyc) begin
        start = 1'b1; fncode = FUNCT_MULTU; op_a = 32'd5; op_b = 32'd6;
      end
      @(posedge clk); #1;
      start = 1'b0; fncode = 6'h00; op_a = '0; op_b = '0;
      o_cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b expected 0", div_by_zero); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h expected 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h expected 0", lo); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mthi_mtlo();
    start = 1'b1; fncode = FUNCT_MTHI; op_a = 32'h1234; push_model(FUNCT_MTHI, 32'h1234, 0);
    @(posedge clk); #1;
    fncode = FUNCT_MTLO; op_a = 32'h5678; push_model(FUNCT_MTLO, 32'h5678, 0);
    checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi got %h expected 00001234", hi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b expected 0", busy); end
    @(posedge clk); #1;
    start = 1'b0; fncode = 6'h00; op_a = '0;
    checks++; if (lo !== 32'h5678) begin errors++; $display("FAIL mtlo got %h expected 00005678", lo); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mtlo_done got %b expected 0", done); end
    // Non-mul/div funct codes are ignored.
    start = 1'b1; fncode = FUNCT_MFHI; op_a = 32'hDEAD;
    @(posedge clk); #1;
    start = 1'b0; fncode = 6'h00; op_a = '0;
    checks++; if ({busy, hi} !== {1'b0, m_hi}) begin errors++; $display("FAIL mfhi_ignored got %b/%h expected 0/%h", busy, hi, m_hi); end
  endtask

  task automatic test_div_by_zero();
    exp_t e;
    push_model(FUNCT_DIVU, 32'd100, 32'd0);
    run_op(FUNCT_DIVU, 32'd100, 32'd0, 0);
    e = sb.pop_front();
    checks++; if (!o_done || o_cyc != e.lat) begin errors++; $display("FAIL dbz_latency got %0d (done %b) expected %0d", o_cyc, o_done, e.lat); end
    checks++; if (o_dbz !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b expected 1", o_dbz); end
    checks++; if (o_hi !== 32'h1234 || o_hi !== e.hi) begin errors++; $display("FAIL dbz_hi got %h expected 00001234", o_hi); end
    checks++; if (o_lo !== 32'h5678 || o_lo !== e.lo) begin errors++; $display("FAIL dbz_lo got %h expected 00005678", o_lo); end
  endtask

  task automatic test_multu_full();
    exp_t e;
    push_model(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    e = sb.pop_front();
    checks++; if (!o_done || o_cyc != 34) begin errors++; $display("FAIL multu_latency got %0d (done %b) expected 34", o_cyc, o_done); end
    checks++; if (o_busy != 33) begin errors++; $display("FAIL multu_busy_cycles got %0d expected 33", o_busy); end
    checks++; if (o_hi !== 32'hFFFFFFFE || o_hi !== e.hi) begin errors++; $display("FAIL multu_hi got %h expected fffffffe", o_hi); end
    checks++; if (o_lo !== 32'h00000001 || o_lo !== e.lo) begin errors++; $display("FAIL multu_lo got %h expected 00000001", o_lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done got %b expected 0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b expected 0", done); end
  endtask

  task automatic test_signed();
    logic [5:0]  fns [3] = '{FUNCT_MULT, FUNCT_DIV, FUNCT_DIV};
    logic [31:0] as  [3] = '{32'hFFFFFFFD, 32'hFFFFFFF9, 32'h80000000};
    logic [31:0] bs  [3] = '{32'd7, 32'd2, 32'hFFFFFFFF};
    logic [31:0] xh  [3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    logic [31:0] xl  [3] = '{32'hFFFFFFEB, 32'hFFFFFFFD, 32'h80000000};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      push_model(fns[i], as[i], bs[i]);
      run_op(fns[i], as[i], bs[i], 0);
      e = sb.pop_front();
      checks++; if (!o_done || o_cyc != e.lat) begin errors++; $display("FAIL signed%0d_latency got %0d expected %0d", i, o_cyc, e.lat); end
      checks++; if (o_hi !== xh[i] || o_hi !== e.hi) begin errors++; $display("FAIL signed%0d_hi got %h expected %h", i, o_hi, xh[i]); end
      checks++; if (o_lo !== xl[i] || o_lo !== e.lo) begin errors++; $display("FAIL signed%0d_lo got %h expected %h", i, o_lo, xl[i]); end
      checks++; if (o_dbz !== 1'b0 || o_spur !== 1'b0) begin errors++; $display("FAIL signed%0d_dbz got %b/%b expected 0/0", i, o_dbz, o_spur); end
    end
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int extra = 0;
    push_model(FUNCT_DIVU, 32'd1000, 32'd7);
    run_op(FUNCT_DIVU, 32'd1000, 32'd7, 5);
    e = sb.pop_front();
    checks++; if (!o_done || o_cyc != 34) begin errors++; $display("FAIL ignore_latency got %0d expected 34", o_cyc); end
    checks++; if (o_hi !== 32'd6 || o_lo !== 32'd142 || o_lo !== e.lo) begin errors++; $display("FAIL ignore_result got %h/%h expected 00000006/0000008e", o_hi, o_lo); end
    repeat (40) begin
      @(posedge clk); #1;
      if (busy || done) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL ignore_no_second_op got %0d busy/done cycles expected 0", extra); end
  endtask

  task automatic test_reset_midop();
    int seen = 0;
    push_model(FUNCT_MTHI, 32'hA5A5A5A5, 0);
    start = 1'b1; fncode = FUNCT_MTHI; op_a = 32'hA5A5A5A5;
    @(posedge clk); #1;
    fncode = FUNCT_DIVU; op_a = 32'd1000; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0; fncode = 6'h00; op_a = '0; op_b = '0;
    for (int c = 1; c < 10; c++) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b expected 0", busy); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midreset_hilo got %h/%h expected 0/0", hi, lo); end
    @(posedge clk); #1;
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midreset_no_done got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_early_term();
    exp_t e;
    push_model(FUNCT_MULTU, 32'h12345678, 32'd3);
    run_op(FUNCT_MULTU, 32'h12345678, 32'd3, 0);
    e = sb.pop_front();
`ifdef MULDIV_EARLY_TERM_EN
    checks++; if (!o_done || o_cyc != 4) begin errors++; $display("FAIL early_latency got %0d expected 4", o_cyc); end
`else
    checks++; if (!o_done || o_cyc != 34) begin errors++; $display("FAIL fixed_latency got %0d expected 34", o_cyc); end
`endif
    checks++; if (o_hi !== 32'h0 || o_lo !== 32'h369D0368 || o_lo !== e.lo) begin errors++; $display("FAIL early_result got %h/%h expected 00000000/369d0368", o_hi, o_lo); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] fn_tab [6] = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO};
    logic [5:0]  fn;
    logic [31:0] a, b;
    exp_t e;
    for (int n = 0; n < 24; n++) begin
      fn = fn_tab[$urandom_range(0, 5)];
      a  = $urandom();
      case ($urandom_range(0, 4))
        0: b = 32'h0;
        1: b = $urandom_range(1, 255);
        2: b = 32'hFFFFFFFF - $urandom_range(0, 3);
        default: b = $urandom();
      endcase
      push_model(fn, a, b);
      if (fn == FUNCT_MTHI || fn == FUNCT_MTLO) begin
        start = 1'b1; fncode = fn; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0; fncode = 6'h00; op_a = '0; op_b = '0;
        checks++; if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin errors++; $display("FAIL b2b%0d_move got %h/%h expected %h/%h", n, hi, lo, m_hi, m_lo); end
      end else begin
        run_op(fn, a, b, 0);
        e = sb.pop_front();
        checks++; if (!o_done || o_cyc != e.lat || o_busy != e.lat - 1) begin errors++; $display("FAIL b2b%0d_timing fn %h got lat %0d busy %0d expected %0d", n, fn, o_cyc, o_busy, e.lat); end
        checks++; if (o_hi !== e.hi || o_lo !== e.lo) begin errors++; $display("FAIL b2b%0d_result fn %h a %h b %h got %h/%h expected %h/%h", n, fn, a, b, o_hi, o_lo, e.hi, e.lo); end
        checks++; if (o_dbz !== e.dbz || o_spur !== 1'b0) begin errors++; $display("FAIL b2b%0d_dbz got %b expected %b", n, o_dbz, e.dbz); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_div_by_zero();
    test_multu_full();
    test_signed();
    test_busy_ignore();
    test_reset_midop();
    test_early_term();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative sequencer for the HI/LO multiply/divide resource in the mips_cpu execute stage.
- Accepts R-type MULT/MULTU/DIV/DIVU/MTHI/MTLO from the decoded funct code and runs a 32-step shift-add multiply or restoring divide.
- Owns the HI/LO registers and raises busy so the pipeline stalls MFHI/MFLO and any further mul/div until the result is committed.

Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is verified.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  issue strobe; sampled only when busy=0
- fncode  input  6  R-type funct of the issuing instruction
- op_a  input  WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source)
- op_b  input  WIDTH  rt value (multiplier / divisor)
- busy  output  1  operation in flight; pipeline must stall mul/div/MFHI/MFLO
- done  output  1  one-cycle pulse on the cycle HI/LO receive a mul/div result
- div_by_zero  output  1  one-cycle pulse alongside done for DIV/DIVU with op_b=0
- hi  output  WIDTH  architectural HI
- lo  output  WIDTH  architectural LO

Behaviour:
- Reset (reset=0, any time, including mid-operation): state=IDLE, busy=0, done=0, div_by_zero=0, hi=0, lo=0, step counter=0. Any in-flight operation is discarded.
- States: IDLE, RUN, FIX.
- IDLE, start=1, fncode MULT/MULTU/DIV/DIVU: latch operands. Signed ops latch magnitudes plus result-sign flags. Set busy=1 on the next edge and go to RUN with counter=0.
- IDLE, start=1, fncode MTHI/MTLO: write op_a to hi/lo on that edge. Stay IDLE. No busy, no done.
- IDLE, start=1, any other fncode: ignored.
- start while busy=1 is ignored. The pipeline guarantees it never occurs; the bench checks that it is ignored.
- RUN multiply:
  - Each cycle, if multiplier bit 0 is set, add the multiplicand into the upper half of a 2*WIDTH accumulator.
  - Then shift the accumulator and multiplier right by 1.
  - Additions are WIDTH+1 bits wide so the carry is kept.
- RUN divide:
  - Each cycle, shift {remainder,quotient} left by 1.
  - Trial-subtract the divisor in WIDTH+1 bits; on a non-negative result, keep the difference and set quotient bit 0.
- RUN to FIX after 32 steps, when counter reaches WIDTH-1.
- FIX: apply sign correction by two's-complement negation:
  - Product negated if sign(a) xor sign(b).
  - Quotient negated if sign(a) xor sign(b).
  - Remainder takes the sign of a.
- FIX commit: hi = product[63:32] or remainder; lo = product[31:0] or quotient. Assert done for one cycle, busy=0, return to IDLE.
- Latency: start accepted at edge N; busy high from edge N+1 through edge N+33; done high in cycle N+34, with hi/lo valid from that edge. Full-length latency is 34 cycles.
- DIV/DIVU with op_b=0: skip RUN and complete in FIX on the next cycle. hi and lo are left unchanged; done=1 and div_by_zero=1.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap, no trap).
- hi/lo hold their old values while busy. The pipeline is responsible for not consuming them.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined: in RUN-multiply, if the remaining multiplier bits are all zero, align the accumulator by the remaining shift count and go to FIX on the next edge. Multiply latency becomes 2 + (index of highest set multiplier bit + 1) cycles; op_b=0 takes 2 cycles. Divide is unaffected.
- Undefined: fixed 34-cycle multiply.

Decomposition:
- Shared package holds:
  - FUNCT_MULT 6'h18, FUNCT_MULTU 6'h19, FUNCT_DIV 6'h1A, FUNCT_DIVU 6'h1B
  - FUNCT_MFHI 6'h10, FUNCT_MTHI 6'h11, FUNCT_MFLO 6'h12, FUNCT_MTLO 6'h13
  - muldiv_state_t enum {IDLE, RUN, FIX}
- One sub-module, muldiv_iter: the accumulator/shift registers and a single-step add/subtract, controlled by mode and step-enable signals.
- muldiv_ctrl keeps the FSM, counter, sign handling and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done exactly 34 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles.
- MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100/0 after MTHI 0x1234, MTLO 0x5678 -> done and div_by_zero pulse 2 cycles after start; hi=0x1234, lo=0x5678.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; no div_by_zero.
- Start DIVU 1000/7; pulse reset low at cycle 10 -> hi=lo=0, busy=0, no done. A second start with MULTU 5x6 at cycle 5 of a running op is ignored and the first result is still committed.
- With MULDIV_EARLY_TERM_EN: MULTU 0x12345678 x 3 -> done 4 cycles after start; hi=0, lo=0x369D0368.
